// File: rtl/sw_cmd_sched.sv
// Crosspoint switch command scheduler: buffers host commands, dispatches them
// one at a time to the switch driver, and keeps a 16x8 shadow of switch states.
module sw_cmd_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       FPGA_CLK_I,
  input  logic       RESET_N_I,
  input  logic       CMD_VALID_I,
  output logic       CMD_READY_O,
  input  logic       CMD_CLR_I,
  input  logic [3:0] CMD_AX_I,
  input  logic [2:0] CMD_AY_I,
  input  logic       CMD_DATA_I,
  output logic       SW_EN_O,
  output logic       SW_CLR_O,
  output logic [3:0] SW_AX_O,
  output logic [2:0] SW_AY_O,
  output logic       SW_DATA_O,
  input  logic       SW_IDLE_I,
  input  logic [3:0] RD_AX_I,
  output logic [7:0] RD_ROW_O,
  output logic       BUSY_O,
  output logic       DONE_O,
  output logic       ERR_O
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef struct packed {
    logic       clr;
    logic [3:0] ax;
    logic [2:0] ay;
    logic       data;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_ISSUE     = 4'b0010,
    S_WAIT_BUSY = 4'b0100,
    S_WAIT_DONE = 4'b1000
  } state_t;

  function automatic logic [7:0] row_write(input logic [7:0] row,
                                           input logic [2:0] ay,
                                           input logic       d);
    logic [7:0] r;
    r     = row;
    r[ay] = d;
    return r;
  endfunction

  cmd_t            fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            rdy_en_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  cmd_t            cmd_in;
  cmd_t            head;

  state_t          state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            shadow_upd;
  logic [7:0]      shadow [16];
  logic [7:0]      rd_row_p1;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Ready stays low through reset and rises on the first edge after release.
  assign CMD_READY_O = rdy_en_q & ~fifo_full;
  assign push        = CMD_VALID_I & CMD_READY_O;
  assign pop         = (state_q == S_IDLE) & ~fifo_empty & SW_IDLE_I;
  assign cmd_in      = '{clr: CMD_CLR_I, ax: CMD_AX_I, ay: CMD_AY_I, data: CMD_DATA_I};
  assign head        = fifo_mem[rd_ptr_q[AW-1:0]];
  assign BUSY_O      = ~fifo_empty | (state_q != S_IDLE);
  assign shadow_upd  = (state_q == S_WAIT_DONE) & SW_IDLE_I;
  assign RD_ROW_O    = rd_row_p1;

  always_ff @(posedge FPGA_CLK_I) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      SW_EN_O   <= 1'b0;
      SW_CLR_O  <= 1'b0;
      SW_AX_O   <= '0;
      SW_AY_O   <= '0;
      SW_DATA_O <= 1'b0;
      DONE_O    <= 1'b0;
      ERR_O     <= 1'b0;
    end else begin
      DONE_O <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            SW_CLR_O  <= head.clr;
            SW_AX_O   <= head.ax;
            SW_AY_O   <= head.ay;
            SW_DATA_O <= head.data;
            SW_EN_O   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          SW_EN_O  <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A driver that never leaves idle loses the command and flags an error.
          if (!SW_IDLE_I) begin
            state_q <= S_WAIT_DONE;
          end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
            ERR_O   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (SW_IDLE_I) begin
            DONE_O  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          SW_EN_O <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
      rd_row_p1 <= '0;
    end else begin
      if (shadow_upd) begin
        if (SW_CLR_O) begin
          for (int i = 0; i < 16; i++) shadow[i] <= '0;
        end else begin
          shadow[SW_AX_O] <= row_write(shadow[SW_AX_O], SW_AY_O, SW_DATA_O);
        end
      end
      rd_row_p1 <= shadow[RD_AX_I];
    end
  end

endmodule
